// File: rtl/clock_pkg.sv
// Shared definitions for the digital-clock display path: active-low
// 7-segment codes, the adjust-field encoding and the display frame layout.
package clock_pkg;

    // Active-low segment codes, bit order {dp,g,f,e,d,c,b,a}, dp off.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // All digit enables released (active-low anodes).
    localparam logic [7:0] AN_OFF = 8'hFF;

    // Field currently being edited in adjust mode.
    typedef enum logic [1:0] {
        ADJ_NONE = 2'd0,
        ADJ_SEC  = 2'd1,
        ADJ_MIN  = 2'd2,
        ADJ_HOUR = 2'd3
    } adj_field_t;

    // One coherent snapshot of the time shown across a scan frame.
    typedef struct packed {
        logic [7:0] hour;
        logic [7:0] min;
        logic [7:0] sec;
    } frame_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low 7-segment pattern (a..g, no dp).
// Nibbles above 9 render as a dash.
module bcd_to_seg
    import clock_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern for the nibble
    always_comb begin
        seg = SEG_DASH[6:0];
        case (bcd)
            4'd0:    seg = SEG_0[6:0];
            4'd1:    seg = SEG_1[6:0];
            4'd2:    seg = SEG_2[6:0];
            4'd3:    seg = SEG_3[6:0];
            4'd4:    seg = SEG_4[6:0];
            4'd5:    seg = SEG_5[6:0];
            4'd6:    seg = SEG_6[6:0];
            4'd7:    seg = SEG_7[6:0];
            4'd8:    seg = SEG_8[6:0];
            4'd9:    seg = SEG_9[6:0];
            default: seg = SEG_DASH[6:0];
        endcase
    end

endmodule

// File: rtl/display_scan.sv
// Multiplexed 8-digit common-anode 7-segment driver for the digital clock.
// Digits 0..5 show sec/min/hour (ones then tens), digits 6..7 stay dark.
// Inputs are snapshotted once per frame so a frame never mixes two times.
// Optional build macro DISPLAY_BLINK_EN: blinks the field selected by
// adj_sel while adjust is high; without it adjust/adj_sel are ignored.
// SCAN_DIV = CLK_HZ/SCAN_HZ must be at least 2.
module display_scan
    import clock_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned SCAN_HZ  = 1000,
    parameter int unsigned BLINK_HZ = 2
) (
    input  logic       CP,
    input  logic       _CR,
    input  logic [7:0] show_hour,
    input  logic [7:0] show_min,
    input  logic [7:0] show_sec,
    input  logic       adjust,
    input  logic [1:0] adj_sel,
    output logic [7:0] an,
    output logic [7:0] seg
);

    localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int unsigned PW       = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

    localparam int unsigned BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int unsigned BW         = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    logic [PW-1:0] pre_cnt;
    logic          scan_tick;
    logic [2:0]    idx;
    logic          run;
    frame_t        frame;

    logic [3:0]    nibble;
    logic          dp_on;
    logic          digit_on;
    adj_field_t    field;
    logic [6:0]    seg_code;
    logic          blank_field;

    assign scan_tick = (pre_cnt == PRE_LAST);

    // Digit-rate prescaler, terminal count produces scan_tick
    always_ff @(posedge CP) begin
        if (!_CR)
            pre_cnt <= '0;
        else if (scan_tick)
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + 1'b1;
    end

    // Digit index; the first tick after reset only arms the scan so that
    // digit 0 is the first digit driven, later ticks advance idx.
    always_ff @(posedge CP) begin
        if (!_CR) begin
            idx <= '0;
            run <= 1'b0;
        end else if (scan_tick) begin
            run <= 1'b1;
            if (run)
                idx <= idx + 3'd1;
        end
    end

    // Frame snapshot taken as the scan wraps from the last digit to digit 0
    always_ff @(posedge CP) begin
        if (!_CR)
            frame <= '0;
        else if (scan_tick && idx == 3'd7)
            frame <= '{hour: show_hour, min: show_min, sec: show_sec};
    end

    // Select the nibble, separator dot and owning field for the active digit
    always_comb begin
        nibble   = '0;
        dp_on    = 1'b0;
        digit_on = 1'b1;
        field    = ADJ_NONE;
        case (idx)
            3'd0: begin nibble = frame.sec[3:0];  field = ADJ_SEC;  end
            3'd1: begin nibble = frame.sec[7:4];  field = ADJ_SEC;  end
            3'd2: begin nibble = frame.min[3:0];  field = ADJ_MIN;  dp_on = 1'b1; end
            3'd3: begin nibble = frame.min[7:4];  field = ADJ_MIN;  end
            3'd4: begin nibble = frame.hour[3:0]; field = ADJ_HOUR; dp_on = 1'b1; end
            3'd5: begin nibble = frame.hour[7:4]; field = ADJ_HOUR; end
            default: digit_on = 1'b0;
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .bcd (nibble),
        .seg (seg_code)
    );

`ifdef DISPLAY_BLINK_EN
    logic [BW-1:0] blink_cnt;
    logic          blink_on;

    // Free-running blink phase, starts in the "on" half after reset
    always_ff @(posedge CP) begin
        if (!_CR) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign blank_field = adjust && !blink_on && (adj_sel != ADJ_NONE) &&
                         (adj_field_t'(adj_sel) == field);
`else
    logic [BW+2:0] unused_blink;

    assign unused_blink = {BLINK_LAST, adjust, adj_sel};
    assign blank_field  = 1'b0;
`endif

    // Registered anode/segment drive; the tick cycle itself loads a dark
    // pattern, giving one dead cycle before every newly selected digit.
    always_ff @(posedge CP) begin
        if (!_CR) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else if (!run || scan_tick || !digit_on || blank_field) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else begin
            an  <= ~(8'b1 << idx);
            seg <= {~dp_on, seg_code};
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan (SCAN_DIV=4, blink half-period 20).
// Honours DISPLAY_BLINK_EN the same way as the design build.
module tb_display_scan;

    localparam int unsigned CLK_HZ   = 1000;
    localparam int unsigned SCAN_HZ  = 250;
    localparam int unsigned BLINK_HZ = 25;
    localparam int D    = 4;     // cycles per digit slot
    localparam int H    = 20;    // cycles per blink half-period
    localparam int HIST = 2048;

    logic       CP = 1'b0;
    logic       _CR = 1'b0;
    logic [7:0] show_hour = '0;
    logic [7:0] show_min  = '0;
    logic [7:0] show_sec  = '0;
    logic       adjust    = 1'b0;
    logic [1:0] adj_sel   = '0;
    logic [7:0] an;
    logic [7:0] seg;

    int errors = 0;
    int checks = 0;
    int k      = 0;      // edges since the most recent reset edge
    bit started = 1'b0;

    logic [7:0] h_sec  [HIST];
    logic [7:0] h_min  [HIST];
    logic [7:0] h_hour [HIST];
    logic       h_adj  [HIST];
    logic [1:0] h_sel  [HIST];

    logic [7:0] f1_an  [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hFF, 8'hFF};
    logic [7:0] f1_seg [8] = '{8'h90, 8'h92, 8'h78, 8'hC0, 8'h30, 8'hA4, 8'hFF, 8'hFF};

    display_scan #(
        .CLK_HZ   (CLK_HZ),
        .SCAN_HZ  (SCAN_HZ),
        .BLINK_HZ (BLINK_HZ)
    ) dut (
        .CP        (CP),
        ._CR       (_CR),
        .show_hour (show_hour),
        .show_min  (show_min),
        .show_sec  (show_sec),
        .adjust    (adjust),
        .adj_sel   (adj_sel),
        .an        (an),
        .seg       (seg)
    );

    always #5 CP = ~CP;

    // Cycle bookkeeping and input history for the model
    always @(posedge CP) begin
        if (!_CR) begin
            k = 0;
            started = 1'b1;
        end else begin
            if (k < HIST) begin
                h_sec[k]  = show_sec;
                h_min[k]  = show_min;
                h_hour[k] = show_hour;
                h_adj[k]  = adjust;
                h_sel[k]  = adj_sel;
            end
            k = k + 1;
        end
    end

    function automatic logic [7:0] digit_code(input logic [3:0] n);
        case (n)
            4'd0: return 8'hC0;  4'd1: return 8'hF9;
            4'd2: return 8'hA4;  4'd3: return 8'hB0;
            4'd4: return 8'h99;  4'd5: return 8'h92;
            4'd6: return 8'h82;  4'd7: return 8'hF8;
            4'd8: return 8'h80;  4'd9: return 8'h90;
            default: return 8'hBF;
        endcase
    endfunction

    // Expected outputs after kk edges since reset, from slot arithmetic:
    // output reflects cycle j=kk-1; ticks end every D-cycle slot; slot m
    // (m>=1) shows digit (m-1)%8 of frame (m-1)/8; frame f>=1 holds inputs
    // from cycle (8f+1)*D-1, frame 0 is all zeros.
    function automatic void model(input int kk, output logic [7:0] e_an,
                                  output logic [7:0] e_seg);
        int j, m, d, f, src;
        logic [7:0] fs, fm, fh;
        logic [3:0] nib;
        e_an  = 8'hFF;
        e_seg = 8'hFF;
        if (kk == 0) return;
        j = kk - 1;
        m = j / D;
        if (m == 0 || (j % D) == D - 1) return;
        d = (m - 1) % 8;
        f = (m - 1) / 8;
        if (d >= 6) return;
        fs = '0; fm = '0; fh = '0;
        if (f > 0) begin
            src = (8 * f + 1) * D - 1;
            fs = h_sec[src];
            fm = h_min[src];
            fh = h_hour[src];
        end
`ifdef DISPLAY_BLINK_EN
        if (h_adj[j] && h_sel[j] != 2'd0 && ((j / H) % 2) == 1 &&
            int'(h_sel[j]) == d / 2 + 1) return;
`endif
        case (d)
            0: nib = fs[3:0];
            1: nib = fs[7:4];
            2: nib = fm[3:0];
            3: nib = fm[7:4];
            4: nib = fh[3:0];
            default: nib = fh[7:4];
        endcase
        e_seg = digit_code(nib);
        if (d == 2 || d == 4) e_seg[7] = 1'b0;
        e_an[d] = 1'b0;
    endfunction

    // Every-cycle comparison against the model
    always @(negedge CP) begin
        logic [7:0] e_an, e_seg;
        if (started && k < HIST) begin
            model(k, e_an, e_seg);
            checks++;
            if (an !== e_an || seg !== e_seg) begin
                errors++;
                $display("FAIL model k=%0d: an=%h seg=%h, expected an=%h seg=%h",
                         k, an, seg, e_an, e_seg);
            end
        end
    end

    task automatic lit(input string name, input logic [7:0] ea, input logic [7:0] es);
        checks++;
        if (an !== ea || seg !== es) begin
            errors++;
            $display("FAIL %s k=%0d: an=%h seg=%h, expected an=%h seg=%h",
                     name, k, an, seg, ea, es);
        end
    endtask

    task automatic at_k(input int n);
        int guard = 0;
        while (k != n && guard < 2000) begin
            @(negedge CP);
            guard++;
        end
        if (k != n) begin
            checks++;
            errors++;
            $display("FAIL wait_k: k=%0d, expected %0d", k, n);
        end
    endtask

    initial begin
        // Reset held three edges, outputs dark
        repeat (3) begin
            @(negedge CP);
            lit("reset_hold", 8'hFF, 8'hFF);
        end
        _CR = 1'b1;
        at_k(4);  lit("first_dead", 8'hFF, 8'hFF);
        at_k(5);  lit("first_digit0", 8'hFE, 8'hC0);

        // 23:07:59 captured at end of frame 0, shown in frame 1
        at_k(6);
        show_sec = 8'h59; show_min = 8'h07; show_hour = 8'h23;
        for (int d = 0; d < 8; d++) begin
            at_k((9 + d) * 4);
            lit("dead_cycle", 8'hFF, 8'hFF);
            if (d == 3) begin
                at_k(49);
                show_sec = 8'h00;     // mid-frame change while idx=3
            end
            at_k((9 + d) * 4 + 2);
            lit("frame1_digit", f1_an[d], f1_seg[d]);
        end
        at_k(70); lit("next_frame_sec0", 8'hFE, 8'hC0);
        at_k(74); lit("next_frame_sec1", 8'hFD, 8'hC0);

        // Non-BCD minute tens shows a dash
        at_k(75); show_min = 8'hA3;
        at_k(110); lit("min_ones_dp", 8'hFB, 8'h30);
        at_k(114); lit("min_tens_dash", 8'hF7, 8'hBF);

        // Adjust minutes
        at_k(116); adjust = 1'b1; adj_sel = 2'd2;
`ifdef DISPLAY_BLINK_EN
        at_k(142); lit("blink_off_d2", 8'hFF, 8'hFF);
        at_k(146); lit("blink_off_d3", 8'hFF, 8'hFF);
`else
        at_k(142); lit("noblink_d2", 8'hFB, 8'h30);
        at_k(146); lit("noblink_d3", 8'hF7, 8'hBF);
`endif
        at_k(150); lit("blink_other_d4", 8'hEF, 8'h30);
        at_k(206); lit("blink_on_d2", 8'hFB, 8'h30);
        at_k(230); lit("blink_other_d0", 8'hFE, 8'hC0);
        at_k(234); lit("blink_other_d1", 8'hFD, 8'hC0);
`ifdef DISPLAY_BLINK_EN
        at_k(238); lit("blink_off_d2b", 8'hFF, 8'hFF);
`else
        at_k(238); lit("noblink_d2b", 8'hFB, 8'h30);
`endif
        at_k(240); adjust = 1'b0;
        at_k(270); lit("adjust_off_d2", 8'hFB, 8'h30);

        // Reset mid-digit while idx=4
        at_k(277);
        _CR = 1'b0;
        @(negedge CP);
        lit("reset_mid", 8'hFF, 8'hFF);
        _CR = 1'b1;
        at_k(4);  lit("restart_dead", 8'hFF, 8'hFF);
        at_k(5);  lit("restart_digit0", 8'hFE, 8'hC0);
        at_k(18); lit("frame_cleared_d3", 8'hF7, 8'hC0);
        at_k(38); lit("restart_frame1_d0", 8'hFE, 8'hC0);
        at_k(50); lit("restart_frame1_d3", 8'hF7, 8'hBF);
        at_k(60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d",
                 errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/display_scan.md
# display_scan

Multiplexed 7-segment driver for the digital clock. Sits downstream of the seconds/minutes/hours counters: consumes their packed-BCD `show_*` buses and drives an 8-digit common-anode display, one digit at a time, from the board clock. During time adjustment it can blink the field being edited.

## Interface
- `CLK_HZ`, 100_000_000, board clock frequency in Hz.
- `SCAN_HZ`, 1000, digit-advance rate in Hz; `SCAN_DIV = CLK_HZ/SCAN_HZ`, must be ≥ 2.
- `BLINK_HZ`, 2, blink frequency (full on+off period) in Hz.
- `CP`  in  1  board clock; all logic on the rising edge.
- `_CR`  in  1  synchronous active-low reset.
- `show_hour`  in  8  packed BCD hours, [7:4] tens, [3:0] ones.
- `show_min`  in  8  packed BCD minutes.
- `show_sec`  in  8  packed BCD seconds.
- `adjust`  in  1  1 = clock in adjust mode.
- `adj_sel`  in  2  field being adjusted: 0 none, 1 sec, 2 min, 3 hour.
- `an`  out  8  digit enables, active-low, one-hot-low or all high.
- `seg`  out  8  segments, active-low: [0]=a … [6]=g, [7]=dp.

## Operation
- Prescaler counts 0..SCAN_DIV-1; `scan_tick` pulses on terminal count.
- Digit index `idx` (3 bits) increments on `scan_tick`, wraps 7→0.
- Digit map: 0 sec ones, 1 sec tens, 2 min ones, 3 min tens, 4 hour ones, 5 hour tens, 6–7 blank (`an` all high, `seg`=8'hFF).
- Snapshot: the three BCD inputs are captured into a 24-bit frame register on the cycle `scan_tick` occurs while `idx`=7, so the new frame starts at digit 0 with a coherent value. Mid-frame input changes never appear until the next frame.
- Decode 0–9 (active-low, dp off): C0,F9,A4,B0,99,92,82,F8,80,90. Nibble >9 shows "-" = 8'hBF.
- dp lit (seg[7]=0) on digits 2 and 4 (field separators).
- `an` for active digit i = ~(8'b1 << i).
- Ghost suppression: on the cycle after each `scan_tick`, `an`=8'hFF (one dead cycle), then the new digit is driven.

## Timing
- Reset (`_CR`=0 at a rising edge): prescaler 0, `idx` 0, frame register 0, blink counter 0 phase "on", `an`=8'hFF, `seg`=8'hFF. Applies mid-frame with no residue.
- First digit drives 2 cycles after `scan_tick` following reset release (register + dead cycle); `an`/`seg` registered, change only together.
- Each digit is driven SCAN_DIV-1 cycles and blanked 1 cycle; full frame = 8·SCAN_DIV cycles.
- Input sampling latency: ≤ one frame + 2 cycles.
- `adjust`/`adj_sel` sampled each cycle, no synchronization beyond CP domain (inputs are CP-domain).

## Configuration
- `DISPLAY_BLINK_EN` defined: blink counter toggles phase every CLK_HZ/(2·BLINK_HZ) cycles, starting "on" after reset. When `adjust`=1 and `adj_sel`≠0, both digits of the selected field are forced blank (`an` high) during "off" phase; other digits unaffected. Blink counter free-runs regardless of `adjust`.
- Undefined: no blink counter, `adj_sel` ignored, all six digits always displayed.

## Structure
- Shared package `clock_pkg`: 7-seg code constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK), field encoding for `adj_sel` (ADJ_NONE/SEC/MIN/HOUR).
- One sub-module `bcd_to_seg` (combinational 4-bit → 7-segment decode) instantiated once on the muxed nibble.

## Test plan
Use CLK_HZ=1000, SCAN_HZ=250 (SCAN_DIV=4), BLINK_HZ=25 (toggle every 20 cycles).
- Reset held 3 cycles then released, inputs 0 -> `an`=FF,`seg`=FF during reset; digit 0 shows `an`=FE,`seg`=C0 after first tick+dead cycle.
- `show_sec`=8'h59, `show_min`=8'h07, `show_hour`=8'h23 -> digits 0..5 show 90,92,78(F8 with dp),C0,30(B0 with dp),A4; `an` FE,FD,FB,F7,EF,DF; digits 6–7 `an`=FF; one all-high cycle between each.
- Change `show_sec` 8'h59→8'h00 while `idx`=3 -> digits 4–5 and remaining frame unchanged; next frame digit 0 shows C0.
- `show_min`=8'hA3 -> digit 3 shows BF.
- Blink build, `adjust`=1, `adj_sel`=2 -> digits 2–3 blank during off phase, shown during on phase; digits 0,1,4,5 always shown. `adjust`=0 -> no blanking.
- Assert `_CR` at `idx`=4 mid-digit -> next edge outputs FF, `idx` 0, frame register cleared, sequence restarts as in scenario 1.
